// File: rtl/ahb_lite_sram_slave_if.sv
`default_nettype none
// ============================================================================
// ahb_lite_sram_slave_if : AHB-Lite bus bundle between a master and the SRAM slave
// Revision: 1.0
// ============================================================================
interface ahb_lite_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
// ahb_lite_sram_slave : AHB-Lite slave, word SRAM, wait states, two-cycle ERROR
// Revision: 1.0
// ============================================================================
module ahb_lite_sram_slave #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_lite_sram_slave_if.slave  bus
);

  localparam int         DEPTH   = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t                state, state_nxt, start_state;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            lane_q;
  logic [1:0]            size_q;
  logic                  write_q;
  logic                  phase_ready;
  logic                  accept;
  logic                  illegal;
  logic                  ready;
  logic                  resp;
  logic                  commit;
  logic [3:0]            byte_en;
  logic                  unused_bits;

  logic [31:0] mem [DEPTH];

  assign unused_bits = ^{bus.HBURST, bus.HTRANS[0]};

  // A new address phase can only land when our own data phase is completing.
  assign phase_ready = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept      = bus.HSEL && bus.HREADY && bus.HTRANS[1] && phase_ready;

  assign illegal = (bus.HSIZE > 3'd2)
                || ((bus.HSIZE == 3'd1) && bus.HADDR[0])
                || ((bus.HSIZE == 3'd2) && (bus.HADDR[1:0] != 2'b00))
                || ((bus.HADDR >> (ADDR_WIDTH + 2)) != 32'd0);

  always_comb begin
    start_state = S_DATA;
    if (illegal) begin
      start_state = S_ERR1;
    end else if (WAIT_STATES > 0) begin
      start_state = S_WAIT;
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ready        = 1'b1;
    resp         = 1'b0;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        resp = (state == S_ERR2);
        if (accept) begin
          state_nxt    = start_state;
          wait_cnt_nxt = 4'd0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        ready = 1'b0;
        if (wait_cnt == WS_LAST) begin
          state_nxt    = S_DATA;
          wait_cnt_nxt = 4'd0;
        end else begin
          wait_cnt_nxt = wait_cnt + 4'd1;
        end
      end
      S_ERR1: begin
        ready     = 1'b0;
        resp      = 1'b1;
        state_nxt = S_ERR2;
      end
      default: begin
        state_nxt    = S_IDLE;
        wait_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      lane_q   <= 2'b00;
      size_q   <= 2'b00;
      write_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (accept) begin
        addr_q  <= bus.HADDR[ADDR_WIDTH+1:2];
        lane_q  <= bus.HADDR[1:0];
        size_q  <= bus.HSIZE[1:0];
        write_q <= bus.HWRITE;
      end
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    byte_en = 4'b0001 << lane_q;
      2'd1:    byte_en = lane_q[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  assign commit = (state == S_DATA) && write_q;

  // The write lands on the edge that ends its DATA cycle, which is never later
  // than the address phase of a following read, so the read's combinational
  // lookup already sees the merged word.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      for (int n = 0; n < 4; n++) begin
        if (byte_en[n]) begin
          mem[addr_q][8*n +: 8] <= bus.HWDATA[8*n +: 8];
        end
      end
    end
  end

  assign bus.HREADYOUT = ready;
  assign bus.HRESP     = resp;
  assign bus.HRDATA    = ((state == S_DATA) && !write_q) ? mem[addr_q] : 32'd0;

endmodule
`default_nettype wire
